vector_mem_sequencer: RTL

//  Parametrised vector load/store sequencer between the vector register datapath and a narrow-port RAM.

---
 rtl/vector_mem_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: serialises one LANES-wide vector into narrow RAM beats.
// Optional feature macro VMEM_STRIDE_EN: strided beat addressing from req_stride (default step 1).
module vector_mem_sequencer #(
    parameter int LANES      = 16,
    parameter int ELEM_W     = 8,
    parameter int BEAT_LANES = 4,
    parameter int ADDR_W     = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic [ADDR_W-1:0]            req_base,
    input  logic [ADDR_W-1:0]            req_stride,
    input  logic [LANES*ELEM_W-1:0]      req_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [LANES*ELEM_W-1:0]      rsp_data,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [BEAT_LANES*ELEM_W-1:0] mem_wdata,
    output logic                         mem_wren,
    output logic                         mem_rden,
    input  logic [BEAT_LANES*ELEM_W-1:0] mem_rdata,
    output logic                         busy
);
    localparam int BEATS = LANES / BEAT_LANES;
    localparam int BW    = BEAT_LANES * ELEM_W;
    localparam int DW    = LANES * ELEM_W;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, RESP} state_t;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [DW-1:0]            data_q, data_d, rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d, step;
    logic [BW-1:0]            mem_wdata_q, mem_wdata_d;
    logic                     mem_wren_q, mem_wren_d, mem_rden_q, mem_rden_d;
    logic                     rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;
    logic                     busy_q, busy_d;
    logic [RD_LAT-1:0]        vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][KW-1:0] idx_pipe_q, idx_pipe_d;
    logic                     accept, last_beat, last_cap, rsp_hs;

    assign accept    = (state_q == IDLE) && req_valid && req_ready_q;
    assign last_beat = (k_q == LAST_K);
    assign last_cap  = vld_pipe_q[RD_LAT-1] && (idx_pipe_q[RD_LAT-1] == LAST_K);
    assign rsp_hs    = rsp_valid_q && rsp_ready;

`ifdef VMEM_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;
    assign step = stride_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       stride_q <= '0;
        else if (accept) stride_q <= req_stride;
    end
`else
    logic unused_stride;
    assign unused_stride = ^req_stride;
    assign step = ADDR_W'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = req_store ? STORE : LOAD;
            STORE:   if (last_beat) state_d = RESP;
            LOAD:    if (last_beat) state_d = DRAIN;
            DRAIN:   if (last_cap)  state_d = RESP;
            RESP:    if (rsp_hs)    state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Each read issue is tagged with its beat index; the tag emerges with the data.
    always_comb begin
        vld_pipe_d[0] = mem_rden_q;
        idx_pipe_d[0] = k_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end
    end

    always_comb begin
        k_d         = k_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        mem_rden_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        req_ready_d = 1'b0;
        busy_d      = (state_d != IDLE);
        // The vector buffer doubles as the load response buffer.
        if (vld_pipe_q[RD_LAT-1])
            data_d[int'(idx_pipe_q[RD_LAT-1])*BW +: BW] = mem_rdata;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    k_d         = '0;
                    data_d      = req_data;
                    mem_addr_d  = req_base;
                    mem_wdata_d = req_data[BW-1:0];
                    mem_wren_d  = req_store;
                    mem_rden_d  = !req_store;
                end
            end
            STORE: begin
                if (!last_beat) begin
                    k_d         = k_q + KW'(1);
                    mem_wren_d  = 1'b1;
                    mem_addr_d  = mem_addr_q + step;
                    mem_wdata_d = data_q[int'(k_d)*BW +: BW];
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_q;
                end
            end
            LOAD: begin
                if (!last_beat) begin
                    k_d        = k_q + KW'(1);
                    mem_rden_d = 1'b1;
                    mem_addr_d = mem_addr_q + step;
                end
            end
            DRAIN: begin
                if (last_cap) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_d;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q         <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            vld_pipe_q  <= '0;
            idx_pipe_q  <= '0;
        end else begin
            k_q         <= k_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            mem_rden_q  <= mem_rden_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            vld_pipe_q  <= vld_pipe_d;
            idx_pipe_q  <= idx_pipe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign mem_rden  = mem_rden_q;
    assign busy      = busy_q;
endmodule
